// File: rtl/amem_seq_ctrl.sv
// Analog memory array sequencer: single or burst program/read operations with pulse timing and ready timeout.
// Define AMEM_VERIFY_EN to add an automatic read-back compare after every program operation.
module amem_seq_ctrl #(
  parameter logic [7:0] TMO_MAX = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_wr,
  input  logic [7:0] cmd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] pw,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_dout,
  input  logic       mem_rdy,
  output logic [7:0] rdata,
  output logic [7:0] status
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_PULSE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;

  logic [2:0] r_state;
  logic       r_op;
  logic       r_vphase;
  logic [3:0] r_cnt;
  logic [7:0] r_pw;
  logic [7:0] r_pcnt;
  logic [7:0] r_tmo;
  logic [7:0] r_addr;
  logic [7:0] r_din;
  logic [7:0] r_rdata;
  logic       r_done;
  logic       r_err_tmo;
  logic       r_err_ovr;
  logic       r_err_vfy;

  logic       w_rd_op;
  logic       w_accept;
  logic       w_tmo_hit;

  // The verify read-back phase drives the array exactly like a user read.
  assign w_rd_op   = r_op | r_vphase;
  assign w_accept  = cmd_wr & cmd[0] & (r_state == S_IDLE);
  assign w_tmo_hit = ({1'b0, r_tmo} + 9'd1) >= {1'b0, TMO_MAX};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= 1'b0;
      r_vphase  <= 1'b0;
      r_cnt     <= 4'd0;
      r_pw      <= 8'd0;
      r_pcnt    <= 8'd0;
      r_tmo     <= 8'd0;
      r_addr    <= 8'd0;
      r_din     <= 8'd0;
      r_rdata   <= 8'd0;
      r_done    <= 1'b0;
      r_err_tmo <= 1'b0;
      r_err_ovr <= 1'b0;
      r_err_vfy <= 1'b0;
    end else begin
      if (cmd_wr && (r_state != S_IDLE)) r_err_ovr <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= cmd[1];
            r_cnt     <= cmd[7:4];
            r_addr    <= addr;
            r_din     <= wdata;
            r_pw      <= (pw == 8'd0) ? 8'd1 : pw;
            r_vphase  <= 1'b0;
            r_done    <= 1'b0;
            r_err_tmo <= 1'b0;
            r_err_ovr <= 1'b0;
            r_err_vfy <= 1'b0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_pcnt  <= r_pw - 8'd1;
          r_state <= S_PULSE;
        end
        S_PULSE: begin
          if (r_pcnt == 8'd0) begin
            r_tmo   <= 8'd0;
            r_state <= S_WAIT;
          end else begin
            r_pcnt <= r_pcnt - 8'd1;
          end
        end
        S_WAIT: begin
          if (mem_rdy) begin
            r_state <= S_CAPTURE;
          end else if (w_tmo_hit) begin
            r_err_tmo <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        S_CAPTURE: begin
`ifdef AMEM_VERIFY_EN
          if (!r_op && !r_vphase) begin
            r_vphase <= 1'b1;
            r_state  <= S_SETUP;
          end else begin
            if (r_vphase && (mem_dout != r_din)) r_err_vfy <= 1'b1;
            if (r_op) r_rdata <= mem_dout;
            r_vphase <= 1'b0;
            r_state  <= S_NEXT;
          end
`else
          if (r_op) r_rdata <= mem_dout;
          r_state <= S_NEXT;
`endif
        end
        S_NEXT: begin
          if (r_cnt == 4'd0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
            r_addr  <= r_addr + 8'd1;
            r_state <= S_SETUP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_addr = r_addr;
  assign mem_din  = r_din;
  assign mem_we   = (r_state == S_PULSE) & ~w_rd_op;
  assign mem_re   = (r_state == S_PULSE) & w_rd_op;
  assign rdata    = r_rdata;
  assign status   = {(r_state != S_IDLE), r_done, r_err_tmo, r_err_ovr, r_err_vfy, r_state};

endmodule

// File: tb/tb_amem_seq_ctrl.sv
// Randomized bench for amem_seq_ctrl against a command-level model of bursts, pulses and status.
// Define AMEM_VERIFY_EN for both files to exercise the read-back variant.
`timescale 1ns/1ps
module tb_amem_seq_ctrl;

  localparam int TMO = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_wr;
  logic [7:0] cmd, addr, wdata, pw;
  logic [7:0] mem_addr, mem_din;
  logic       mem_we, mem_re;
  logic [7:0] mem_dout;
  logic       mem_rdy;
  logic [7:0] rdata, status;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    bit         rd;
    logic [7:0] a;
    logic [7:0] d;
    int         len;
    bit         moved;
  } pulse_t;

  // Array environment: initial contents, plus cells the DUT has programmed.
  logic [7:0] arr [256];
  logic [7:0] wr_arr [256];
  bit         wr_v [256];
  logic [7:0] flip = 8'h00;
  int         rdy_mode = 0;

  // Observed pulses, written only by the monitor.
  pulse_t pl [4096];
  int     np = 0;
  pulse_t cur;
  bit     in_p = 1'b0;

  // Model state.
  logic [7:0] exp_mem [256];
  logic [7:0] exp_rd = 8'h00;
  logic [7:0] exp_st = 8'h00;

  always #5 clk = ~clk;

  assign mem_dout = (wr_v[mem_addr] ? wr_arr[mem_addr] : arr[mem_addr]) ^ flip;

  amem_seq_ctrl dut (
    .clk(clk), .rst(rst), .cmd_wr(cmd_wr), .cmd(cmd), .addr(addr), .wdata(wdata), .pw(pw),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout), .mem_rdy(mem_rdy), .rdata(rdata), .status(status)
  );

  always @(negedge clk) begin
    if (mem_we || mem_re) begin
      if (!in_p) begin
        cur.rd = mem_re; cur.a = mem_addr; cur.d = mem_din; cur.len = 1; cur.moved = 1'b0;
        in_p = 1'b1;
      end else begin
        cur.len = cur.len + 1;
        if (mem_addr != cur.a) cur.moved = 1'b1;
      end
      if (mem_we) begin
        wr_arr[mem_addr] = mem_din;
        wr_v[mem_addr]   = 1'b1;
      end
    end else if (in_p) begin
      if (np < 4096) pl[np] = cur;
      np = np + 1;
      in_p = 1'b0;
    end
  end

  initial begin
    mem_rdy = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       mem_rdy = 1'b1;
        1:       mem_rdy = ($urandom_range(0, 3) != 0);
        default: mem_rdy = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, follow it to completion and compare against the model.
  task automatic run_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] p, input int mode, input int ovr_at);
    pulse_t ex [64];
    int     ne, base, n, nops, pe, per, exp_n, got_n;
    bit     start, op, ovr, vfy_en;
    logic [7:0] ca;
`ifdef AMEM_VERIFY_EN
    vfy_en = 1'b1;
`else
    vfy_en = 1'b0;
`endif
    start = c[0];
    op    = c[1];
    nops  = int'(c[7:4]) + 1;
    pe    = (p == 8'd0) ? 1 : int'(p);
    ovr   = start && (ovr_at > 0);
    ne    = 0;
    exp_n = -1;

    if (start) begin
      for (int i = 0; i < nops; i++) begin
        ca = a + 8'(i);
        ex[ne].rd = op; ex[ne].a = ca; ex[ne].d = wd; ex[ne].len = pe; ex[ne].moved = 1'b0; ne++;
        if (vfy_en && !op) begin
          ex[ne].rd = 1'b1; ex[ne].a = ca; ex[ne].d = wd; ex[ne].len = pe; ex[ne].moved = 1'b0; ne++;
        end
        if (mode == 2) break;
      end
      per = (vfy_en && !op) ? (2 * (3 + pe) + 1) : (4 + pe);
      if (mode == 2) begin
        ne    = 1;
        exp_n = 1 + pe + TMO;
        exp_st = 8'h20 | (ovr ? 8'h10 : 8'h00);
        if (!op) exp_mem[a] = wd;
      end else begin
        if (mode == 0) exp_n = nops * per;
        exp_st = 8'h40 | (ovr ? 8'h10 : 8'h00) |
                 ((vfy_en && !op && flip != 8'h00) ? 8'h08 : 8'h00);
        if (op) exp_rd = exp_mem[8'(a + 8'(nops - 1))];
        else for (int i = 0; i < nops; i++) exp_mem[8'(a + 8'(i))] = wd;
      end
    end else begin
      exp_n = 0;
    end

    base = np;
    rdy_mode = mode;
    cmd = c; addr = a; wdata = wd; pw = p; cmd_wr = 1'b1;
    @(negedge clk);
    cmd_wr = 1'b0;
    n = 0;
    while (status[7] && n < 20000) begin
      n++;
      if (n == ovr_at) begin
        check("ovr_in_pulse_state", 32'(status[2:0]), 32'd2);
        cmd_wr = 1'b1; cmd = 8'($urandom) | 8'h01; addr = 8'($urandom); pw = 8'($urandom);
      end else begin
        cmd_wr = 1'b0;
      end
      @(negedge clk);
    end
    cmd_wr = 1'b0;
    rdy_mode = 0;

    check("done_within_bound", 32'(n < 20000), 32'd1);
    if (exp_n >= 0) check("busy_cycles", 32'(n), 32'(exp_n));
    got_n = np - base;
    check("pulse_count", 32'(got_n), 32'(ne));
    for (int i = 0; i < ne && i < got_n; i++) begin
      check("pulse_kind", 32'(pl[base + i].rd), 32'(ex[i].rd));
      check("pulse_addr", 32'(pl[base + i].a), 32'(ex[i].a));
      check("pulse_len", 32'(pl[base + i].len), 32'(ex[i].len));
      check("pulse_addr_stable", 32'(pl[base + i].moved), 32'd0);
      if (!ex[i].rd) check("pulse_din", 32'(pl[base + i].d), 32'(ex[i].d));
    end
    check("status", 32'(status), 32'(exp_st));
    check("rdata", 32'(rdata), 32'(exp_rd));
    check("strobes_idle", 32'({mem_we, mem_re}), 32'd0);
  endtask

  initial begin
    logic [7:0] rc, ra, rw, rp, rn;
    int         rm, ro;

    for (int i = 0; i < 256; i++) begin
      arr[i]     = 8'($urandom);
      exp_mem[i] = arr[i];
    end
    rst = 1'b1; cmd_wr = 1'b0; cmd = 8'h00; addr = 8'h00; wdata = 8'h00; pw = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_status", 32'(status), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_din", 32'(mem_din), 32'd0);
    check("reset_strobes", 32'({mem_we, mem_re}), 32'd0);

    // Directed scenarios.
    run_cmd(8'h01, 8'h10, 8'hA5, 8'd3, 0, 0);
    arr[8'h20] = 8'h5A; exp_mem[8'h20] = 8'h5A;
    run_cmd(8'h03, 8'h20, 8'h00, 8'd0, 0, 0);
    check("read_value", 32'(rdata), 32'h5A);
    run_cmd(8'h21, 8'hFF, 8'h66, 8'd2, 0, 0);
    run_cmd(8'h20, 8'h44, 8'h11, 8'd2, 0, 0);
    run_cmd(8'h21, 8'h30, 8'h77, 8'd1, 2, 0);
    run_cmd(8'h01, 8'h40, 8'h12, 8'd5, 0, 2);
    run_cmd(8'hF3, 8'hF8, 8'h00, 8'd1, 1, 0);

    // Reset while waiting on mem_rdy mid-burst.
    rdy_mode = 2;
    cmd = 8'h23; addr = 8'h50; wdata = 8'h00; pw = 8'd2; cmd_wr = 1'b1;
    @(negedge clk);
    cmd_wr = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_wait", 32'(status[2:0]), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    check("rst_status", 32'(status), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_strobes", 32'({mem_we, mem_re}), 32'd0);
    repeat (4) @(negedge clk);
    check("rst_stays_idle", 32'(status), 32'd0);
    exp_rd = 8'h00; exp_st = 8'h00;

`ifdef AMEM_VERIFY_EN
    flip = 8'h01;
    run_cmd(8'h01, 8'h60, 8'h3C, 8'd2, 0, 0);
    flip = 8'h00;
`endif

    // Randomized commands.
    for (int t = 0; t < 30; t++) begin
      rn = 8'($urandom_range(0, 15));
      rc = {rn[3:0], 2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0)};
      ra = 8'($urandom);
      rw = 8'($urandom);
      rp = 8'($urandom_range(0, 6));
      rm = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      ro = (rm == 0 && rp != 8'd0 && $urandom_range(0, 3) == 0) ? 2 : 0;
      run_cmd(rc, ra, rw, rp, rm, ro);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
